// File: rtl/sha256_block_compress.sv
// Iterative SHA-256 compression of one 512-bit block, one round per clock; done pulses ROUNDS+1 edges after start.
// No backpressure: start is ignored while busy; optional COMPRESS_CHAIN_EN adds a chain input that reuses hash_out.
module sha256_block_compress #(
    parameter int ROUNDS = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [511:0]  block,
    input  logic [255:0]  hash_in,
    input  logic [2047:0] constant_values,
`ifdef COMPRESS_CHAIN_EN
    input  logic          chain,
`endif
    output logic          busy,
    output logic          done,
    output logic [255:0]  hash_out
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t       state_q, state_d;
    logic [5:0]   t_q, t_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [255:0] hash_out_q, hash_out_d;
    logic [31:0]  v_q [8];
    logic [31:0]  v_d [8];
    logic [31:0]  saved_q [8];
    logic [31:0]  saved_d [8];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];

    logic [255:0] chain_val;
    logic [10:0]  k_lsb;
    logic [31:0]  k_t;
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [31:0]  w_new;

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hash_out_d = hash_out_q;
        v_d        = v_q;
        saved_d    = saved_q;
        w_d        = w_q;

        chain_val = hash_in;
`ifdef COMPRESS_CHAIN_EN
        if (chain) begin
            chain_val = hash_out_q;
        end
`endif

        // K0 sits in the top word, so K[t] starts 32*t bits below bit 2016.
        k_lsb = 11'd2016 - {t_q, 5'd0};
        k_t   = constant_values[k_lsb +: 32];

        t1 = v_q[7] + big_s1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_t + w_q[0];
        t2 = big_s0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        // w_q[0] holds W[t]; the word entering at the top is W[t+16].
        w_new = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block[511 - 32*i -: 32];
                    end
                    for (int i = 0; i < 8; i++) begin
                        v_d[i]     = chain_val[255 - 32*i -: 32];
                        saved_d[i] = chain_val[255 - 32*i -: 32];
                    end
                    t_d     = 6'd0;
                    busy_d  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                v_d[0] = t1 + t2;
                v_d[1] = v_q[0];
                v_d[2] = v_q[1];
                v_d[3] = v_q[2];
                v_d[4] = v_q[3] + t1;
                v_d[5] = v_q[4];
                v_d[6] = v_q[5];
                v_d[7] = v_q[6];
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i + 1];
                end
                w_d[15] = w_new;
                if (t_q == LAST_T) begin
                    t_d     = 6'd0;
                    state_d = FINAL;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    hash_out_d[255 - 32*i -: 32] = saved_q[i] + v_q[i];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            t_q        <= 6'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hash_out_q <= '0;
            for (int i = 0; i < 8; i++) begin
                v_q[i]     <= '0;
                saved_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hash_out_q <= hash_out_d;
            v_q        <= v_d;
            saved_q    <= saved_d;
            w_q        <= w_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hash_out = hash_out_q;

endmodule
